draw_rect: RTL and testbench

// - Pixel stage directly downstream of vga_timing (800x600@60, 40 MHz pixel clock).
// - Consumes the timing bus and a background colour; overlays one solid rectangle.
// - Position is sampled once per frame, so the picture never tears.
// - Re-emits the timing bus delayed to match its own colour latency, so further draw stages can chain.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_delay.sv | 30 +++
 rtl/draw_rect.sv | 112 +++++++++++
 tb/tb_draw_rect.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and the timing-bus type for the 800x600@60 pixel pipeline.
// Every draw stage imports this package so that bus widths stay consistent.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
    localparam int RGB_W      = 12;
    localparam int HCNT_W     = 11;
    localparam int POS_W      = 12;
    localparam int CMP_W      = 13;

    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic [HCNT_W-1:0] vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
    } vga_timing_t;

    localparam int TIMING_W = $bits(vga_timing_t);

    // True when cnt lies in [start, start+len); one extra bit keeps start+len from wrapping.
    function automatic logic in_span(
        input logic [HCNT_W-1:0] cnt,
        input logic [POS_W-1:0]  start,
        input logic [CMP_W-1:0]  len
    );
        logic [CMP_W-1:0] cnt_w;
        logic [CMP_W-1:0] start_w;
        cnt_w   = CMP_W'(cnt);
        start_w = CMP_W'(start);
        return (cnt_w >= start_w) && (cnt_w < start_w + len);
    endfunction

endpackage

// File: rtl/vga_delay.sv
// Generic fixed-latency delay line with asynchronous reset.
// Used to keep the timing bus and colour aligned through a draw stage.
module vga_delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [CLK_DEL-1:0][WIDTH-1:0] pipe_q;

    // NOTE: every stage is reset, not only the last one, so the pipe refills with zeros after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage take the previous stage's old value.
            pipe_q[0] <= din_i;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays one solid rectangle on the background video; position is taken once per frame
// at the rising edge of vblnk, and the timing bus is re-emitted with the same 2-clk latency.
module draw_rect
    import vga_pkg::*;
#(
    parameter int               RECT_W     = 64,
    parameter int               RECT_H     = 48,
    parameter logic [RGB_W-1:0] RECT_COLOR = 12'hF80,
    parameter logic [POS_W-1:0] X_INIT     = '0,
    parameter logic [POS_W-1:0] Y_INIT     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HCNT_W-1:0] in_hcount,
    input  logic [HCNT_W-1:0] in_vcount,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_hblnk,
    input  logic              in_vblnk,
    input  logic [RGB_W-1:0]  in_rgb,
    input  logic [POS_W-1:0]  xpos,
    input  logic [POS_W-1:0]  ypos,
    output logic [HCNT_W-1:0] out_hcount,
    output logic [HCNT_W-1:0] out_vcount,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_hblnk,
    output logic              out_vblnk,
    output logic [RGB_W-1:0]  out_rgb
);

    localparam logic [CMP_W-1:0] RECT_W_L = CMP_W'(RECT_W);
    localparam logic [CMP_W-1:0] RECT_H_L = CMP_W'(RECT_H);

    vga_timing_t      timing_in;
    vga_timing_t      timing_out;
    logic [RGB_W-1:0] rgb_q;

    logic             vblnk_prev_q;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             hit_q, hit_d;
    logic             blank_q, blank_d;
    logic [RGB_W-1:0] out_rgb_q, out_rgb_d;
    logic             frame_start;

    assign timing_in = '{
        hcount: in_hcount,
        vcount: in_vcount,
        hsync:  in_hsync,
        vsync:  in_vsync,
        hblnk:  in_hblnk,
        vblnk:  in_vblnk
    };

    vga_delay #(
        .WIDTH   (TIMING_W),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk    (clk),
        .rst    (rst),
        .din_i  (timing_in),
        .dout_o (timing_out)
    );

    vga_delay #(
        .WIDTH   (RGB_W),
        .CLK_DEL (1)
    ) u_rgb_delay (
        .clk    (clk),
        .rst    (rst),
        .din_i  (in_rgb),
        .dout_o (rgb_q)
    );

    // NOTE: every output of this block is written on every path, so no latch can be inferred.
    always_comb begin
        frame_start = in_vblnk & ~vblnk_prev_q;
        x_d         = frame_start ? xpos : x_q;
        y_d         = frame_start ? ypos : y_q;
        hit_d       = in_span(in_hcount, x_q, RECT_W_L) && in_span(in_vcount, y_q, RECT_H_L);
        blank_d     = in_hblnk | in_vblnk;
        out_rgb_d   = blank_q ? '0 : (hit_q ? RECT_COLOR : rgb_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_q          <= X_INIT;
            y_q          <= Y_INIT;
            hit_q        <= 1'b0;
            blank_q      <= 1'b0;
            out_rgb_q    <= '0;
        end else begin
            vblnk_prev_q <= in_vblnk;
            x_q          <= x_d;
            y_q          <= y_d;
            hit_q        <= hit_d;
            blank_q      <= blank_d;
            out_rgb_q    <= out_rgb_d;
        end
    end

    assign out_hcount = timing_out.hcount;
    assign out_vcount = timing_out.vcount;
    assign out_hsync  = timing_out.hsync;
    assign out_vsync  = timing_out.vsync;
    assign out_hblnk  = timing_out.hblnk;
    assign out_vblnk  = timing_out.vblnk;
    assign out_rgb    = out_rgb_q;

endmodule

// File: tb/tb_draw_rect.sv
// Bench for draw_rect: drives compressed scan patterns of the 800x600 timing and compares
// every output cycle against a pixel-level model of the rectangle overlay.
module tb_draw_rect;

    localparam int          RW = 64;
    localparam int          RH = 48;
    localparam logic [11:0] RC = 12'hF80;
    localparam logic [11:0] BG = 12'h8AC;
    localparam int          XI = 0;
    localparam int          YI = 0;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] in_hcount, in_vcount;
    logic        in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [11:0] in_rgb, xpos, ypos;
    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;

    int          total   = 0;
    int          bad     = 0;
    int          f80_cnt = 0;
    int          m_x, m_y;
    bit          m_prev;
    logic [11:0] bg = BG;
    obs_t        exp_q[$];

    draw_rect #(
        .RECT_W     (RW),
        .RECT_H     (RH),
        .RECT_COLOR (RC),
        .X_INIT     (12'(XI)),
        .Y_INIT     (12'(YI))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_hcount  (in_hcount),
        .in_vcount  (in_vcount),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_hblnk   (in_hblnk),
        .in_vblnk   (in_vblnk),
        .in_rgb     (in_rgb),
        .xpos       (xpos),
        .ypos       (ypos),
        .out_hcount (out_hcount),
        .out_vcount (out_vcount),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_hblnk  (out_hblnk),
        .out_vblnk  (out_vblnk),
        .out_rgb    (out_rgb)
    );

    always #5 clk = ~clk;

    // Standard 800x600@60 timing derived from the counters.
    task automatic set_pix(input int h, input int v);
        in_hcount = 11'(h);
        in_vcount = 11'(v);
        in_hblnk  = (h >= 800);
        in_hsync  = (h >= 840) && (h < 968);
        in_vblnk  = (v >= 600);
        in_vsync  = (v >= 601) && (v < 605);
        in_rgb    = bg;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back('0);
        m_x    = XI;
        m_y    = YI;
        m_prev = 1'b0;
    endtask

    // One pixel clock: predict the pixel for the current inputs, advance, compare the output due now.
    task automatic drive_cycle();
        obs_t e;
        obs_t act;
        int   hh, vv;
        hh    = int'(in_hcount);
        vv    = int'(in_vcount);
        e.h   = in_hcount;
        e.v   = in_vcount;
        e.hs  = in_hsync;
        e.vs  = in_vsync;
        e.hb  = in_hblnk;
        e.vb  = in_vblnk;
        if (in_hblnk || in_vblnk)
            e.rgb = 12'h000;
        else if (hh >= m_x && hh < m_x + RW && vv >= m_y && vv < m_y + RH)
            e.rgb = RC;
        else
            e.rgb = in_rgb;
        if (!m_prev && in_vblnk) begin
            m_x = int'(xpos);
            m_y = int'(ypos);
        end
        m_prev = in_vblnk;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        act = '{h: out_hcount, v: out_vcount, hs: out_hsync, vs: out_vsync,
                hb: out_hblnk, vb: out_vblnk, rgb: out_rgb};
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL pipe: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                         act.h, act.v, act.hs, act.vs, act.hb, act.vb, act.rgb,
                         e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb);
            end
        end
        if (out_rgb === RC) f80_cnt++;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int v = y0; v <= y1; v++) begin
            for (int h = x0; h <= x1; h++) begin
                set_pix(h, v);
                drive_cycle();
            end
            set_pix(900, v);
            drive_cycle();
        end
    endtask

    // Enter vertical blank; the new position is presented in the same cycle as the vblnk rise.
    task automatic vblank_pulse(input int nx, input int ny);
        set_pix(0, 599);
        drive_cycle();
        for (int v = 600; v < 606; v++) begin
            for (int h = 0; h < 3; h++) begin
                if (v == 600 && h == 0) begin
                    xpos = 12'(nx);
                    ypos = 12'(ny);
                end
                set_pix(h, v);
                drive_cycle();
            end
        end
    endtask

    task automatic sample_pix(input int h, input int v, output logic [11:0] rgb);
        set_pix(h, v);
        drive_cycle();
        set_pix(900, v);
        drive_cycle();
        rgb = out_rgb;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        bg   = BG;
        xpos = 12'd0;
        ypos = 12'd0;
        set_pix(0, 0);
        #1;
        total++;
        if ({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got h=%0d v=%0d rgb=%h, want all zero", out_hcount, out_vcount, out_rgb);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_rgb !== 12'h000 || out_hcount !== 11'd0) begin
            bad++;
            $display("FAIL release_first: got rgb=%h h=%0d, want rgb=000 h=0", out_rgb, out_hcount);
        end
        set_pix(5, 5);
        drive_cycle();
        total++;
        if (out_rgb !== 12'h000) begin
            bad++;
            $display("FAIL release_second: got rgb=%h, want 000", out_rgb);
        end
    endtask

    task automatic test_basic();
        int          ph[5] = '{100, 163, 99, 164, 100};
        int          pv[5] = '{50, 97, 50, 50, 98};
        logic [11:0] pe[5] = '{RC, RC, BG, BG, BG};
        logic [11:0] got;
        vblank_pulse(100, 50);
        f80_cnt = 0;
        scan(96, 168, 46, 102);
        total++;
        if (f80_cnt != RW * RH) begin
            bad++;
            $display("FAIL basic_count: got %0d rect pixels, want %0d", f80_cnt, RW * RH);
        end
        for (int i = 0; i < 5; i++) begin
            sample_pix(ph[i], pv[i], got);
            total++;
            if (got !== pe[i]) begin
                bad++;
                $display("FAIL basic_pix(%0d,%0d): got %h, want %h", ph[i], pv[i], got, pe[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [10:0] ph, pv;
        logic        phs;
        for (int i = 0; i < 300; i++) begin
            set_pix($urandom_range(0, 1055), $urandom_range(0, 627));
            drive_cycle();
            if (i > 0) begin
                total++;
                if ({out_hcount, out_vcount, out_hsync} !== {ph, pv, phs}) begin
                    bad++;
                    $display("FAIL latency: got h=%0d v=%0d hs=%b, want h=%0d v=%0d hs=%b",
                             out_hcount, out_vcount, out_hsync, ph, pv, phs);
                end
            end
            if (out_hblnk || out_vblnk) begin
                total++;
                if (out_rgb !== 12'h000) begin
                    bad++;
                    $display("FAIL blank_rgb: got %h, want 000", out_rgb);
                end
            end
            ph  = in_hcount;
            pv  = in_vcount;
            phs = in_hsync;
        end
    endtask

    task automatic test_mid_frame_change();
        logic [11:0] got;
        vblank_pulse(100, 180);
        scan(90, 380, 195, 199);
        xpos = 12'd300;
        scan(90, 380, 200, 205);
        sample_pix(100, 210, got);
        total++;
        if (got !== RC) begin
            bad++;
            $display("FAIL same_frame_old_x: got %h, want %h", got, RC);
        end
        sample_pix(300, 210, got);
        total++;
        if (got !== BG) begin
            bad++;
            $display("FAIL same_frame_new_x: got %h, want %h", got, BG);
        end
        vblank_pulse(300, 180);
        sample_pix(300, 210, got);
        total++;
        if (got !== RC) begin
            bad++;
            $display("FAIL next_frame_new_x: got %h, want %h", got, RC);
        end
        sample_pix(100, 210, got);
        total++;
        if (got !== BG) begin
            bad++;
            $display("FAIL next_frame_old_x: got %h, want %h", got, BG);
        end
        f80_cnt = 0;
        scan(290, 370, 178, 230);
        total++;
        if (f80_cnt != RW * RH) begin
            bad++;
            $display("FAIL next_frame_count: got %0d, want %0d", f80_cnt, RW * RH);
        end
    endtask

    task automatic test_clip();
        int          ph[5] = '{780, 799, 779, 800, 790};
        int          pv[5] = '{590, 599, 595, 595, 600};
        logic [11:0] pe[5] = '{RC, RC, BG, 12'h000, 12'h000};
        logic [11:0] got;
        vblank_pulse(780, 590);
        f80_cnt = 0;
        scan(760, 830, 580, 605);
        total++;
        if (f80_cnt != 20 * 10) begin
            bad++;
            $display("FAIL clip_count: got %0d, want %0d", f80_cnt, 200);
        end
        for (int i = 0; i < 5; i++) begin
            sample_pix(ph[i], pv[i], got);
            total++;
            if (got !== pe[i]) begin
                bad++;
                $display("FAIL clip_pix(%0d,%0d): got %h, want %h", ph[i], pv[i], got, pe[i]);
            end
        end
        vblank_pulse(4060, 0);
        f80_cnt = 0;
        scan(0, 100, 0, 20);
        total++;
        if (f80_cnt != 0) begin
            bad++;
            $display("FAIL offscreen_4060: got %0d rect pixels, want 0", f80_cnt);
        end
        vblank_pulse(4000, 0);
        f80_cnt = 0;
        scan(0, 70, 0, 5);
        total++;
        if (f80_cnt != 0) begin
            bad++;
            $display("FAIL offscreen_4000: got %0d rect pixels, want 0", f80_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] got;
        vblank_pulse(200, 250);
        scan(380, 399, 300, 300);
        set_pix(400, 300);
        xpos = 12'd500;
        ypos = 12'd400;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb} !== '0) begin
            bad++;
            $display("FAIL rst_async: got h=%0d v=%0d rgb=%h, want all zero", out_hcount, out_vcount, out_rgb);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_hcount, out_vcount, out_hblnk, out_vblnk, out_rgb} !== '0) begin
                bad++;
                $display("FAIL rst_hold: got h=%0d v=%0d rgb=%h, want all zero", out_hcount, out_vcount, out_rgb);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        f80_cnt = 0;
        scan(0, 70, 0, 52);
        total++;
        if (f80_cnt != RW * RH) begin
            bad++;
            $display("FAIL init_pos_count: got %0d, want %0d", f80_cnt, RW * RH);
        end
        sample_pix(10, 10, got);
        total++;
        if (got !== RC) begin
            bad++;
            $display("FAIL init_pos_pix: got %h, want %h", got, RC);
        end
        vblank_pulse(500, 400);
        sample_pix(510, 410, got);
        total++;
        if (got !== RC) begin
            bad++;
            $display("FAIL latched_pos_pix: got %h, want %h", got, RC);
        end
        sample_pix(10, 10, got);
        total++;
        if (got !== BG) begin
            bad++;
            $display("FAIL init_pos_gone: got %h, want %h", got, BG);
        end
    endtask

    task automatic test_full_frames();
        int x, y;
        for (int f = 0; f < 2; f++) begin
            x = $urandom_range(0, 800 - RW);
            y = $urandom_range(0, 600 - RH);
            vblank_pulse(x, y);
            f80_cnt = 0;
            scan((x < 6) ? 0 : x - 6, (x + RW + 5 > 799) ? 799 : x + RW + 5,
                 (y < 6) ? 0 : y - 6, (y + RH + 5 > 599) ? 599 : y + RH + 5);
            total++;
            if (f80_cnt != RW * RH) begin
                bad++;
                $display("FAIL frame_count(%0d,%0d): got %0d, want %0d", x, y, f80_cnt, RW * RH);
            end
        end
    endtask

    task automatic test_random();
        int h, v;
        for (int f = 0; f < 6; f++) begin
            bg = 12'($urandom);
            vblank_pulse($urandom_range(0, 900), $urandom_range(0, 700));
            for (int i = 0; i < 500; i++) begin
                xpos = 12'($urandom);
                ypos = 12'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    h = m_x - 2 + int'($urandom_range(0, RW + 3));
                    v = m_y - 2 + int'($urandom_range(0, RH + 3));
                end else begin
                    h = $urandom_range(0, 1055);
                    v = $urandom_range(0, 627);
                end
                if (h < 0 || h > 1055) h = $urandom_range(0, 1055);
                if (v < 0 || v > 627) v = $urandom_range(0, 627);
                set_pix(h, v);
                drive_cycle();
            end
        end
        bg = BG;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_mid_frame_change();
        test_clip();
        test_reset_mid_frame();
        test_full_frames();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
